// File: rtl/flit_requester.sv
// flit_requester: per-port flit buffer plus request FSM.
// Flits are queued in a DEPTH-entry FIFO. A header at the FIFO head raises a
// request to the port arbiter, and the packet is forwarded one flit per granted
// cycle until its tail. Non-header flits that arrive outside a packet are dropped
// and flagged in a sticky error bit.
// Optional feature: define FLIT_LEN_CHECK_EN to also flag packets whose flit
// count disagrees with the header length field.
// Assumes DW >= 12, because the header length is carried in data bits [11:0].
module flit_requester #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [2:0]    in_flit_id,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          req,
  output logic [2:0]    flit_id,
  output logic [11:0]   length,
  input  logic          grant,
  output logic          out_valid,
  output logic [2:0]    out_flit_id,
  output logic [DW-1:0] out_data,
  output logic          err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [2:0]  ID_HEAD  = 3'b001;
  localparam logic [2:0]  ID_TAIL  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_SEND = 2'b10
  } state_t;

  logic [2:0]    mem_id_r   [DEPTH];
  logic [DW-1:0] mem_data_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          fwd_s;
  logic          err_set_s;
  logic [2:0]    head_id_s;
  logic [DW-1:0] head_data_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic [11:0]   cnt_r;
  logic [11:0]   cnt_nx_s;
  logic [11:0]   length_r;
  logic [11:0]   length_nx_s;
  logic          req_r;
  logic          err_r;
  logic          out_valid_r;
  logic [2:0]    out_flit_id_r;
  logic [DW-1:0] out_data_r;

  assign empty_s     = (count_r == '0);
  assign full_s      = (count_r == FULL_LVL);
  assign push_s      = in_valid & ~full_s;
  assign head_id_s   = empty_s ? 3'b000 : mem_id_r[rd_ptr_r];
  assign head_data_s = mem_data_r[rd_ptr_r];

  assign in_ready    = ~full_s;
  assign flit_id     = head_id_s;
  assign req         = req_r;
  assign length      = length_r;
  assign err         = err_r;
  assign out_valid   = out_valid_r;
  assign out_flit_id = out_flit_id_r;
  assign out_data    = out_data_r;

  // FIFO storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_id_r[wr_ptr_r]   <= in_flit_id;
      mem_data_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next-state, pop and error decode from the current state and the FIFO head
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    length_nx_s = length_r;
    pop_s       = 1'b0;
    fwd_s       = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (empty_s) begin
          state_nx_s = S_IDLE;
        end else if (head_id_s == ID_HEAD) begin
          length_nx_s = head_data_s[11:0];
          state_nx_s  = S_REQ;
`ifdef FLIT_LEN_CHECK_EN
          if (head_data_s[11:0] < 12'd2) err_set_s = 1'b1;
          else                           err_set_s = 1'b0;
`endif
        end else begin
          // stray body/tail outside a packet: drop it
          pop_s     = 1'b1;
          err_set_s = 1'b1;
        end
      end
      S_REQ: begin
        if (grant && !empty_s) begin
          pop_s      = 1'b1;
          fwd_s      = 1'b1;
          cnt_nx_s   = 12'd1;
          state_nx_s = S_SEND;
        end else begin
          state_nx_s = S_REQ;
        end
      end
      S_SEND: begin
        if (grant && !empty_s) begin
          pop_s    = 1'b1;
          fwd_s    = 1'b1;
          cnt_nx_s = cnt_r + 12'd1;
          if (head_id_s == ID_TAIL) begin
            state_nx_s = S_IDLE;
`ifdef FLIT_LEN_CHECK_EN
            if (cnt_nx_s != length_r) err_set_s = 1'b1;
            else                      err_set_s = 1'b0;
`endif
          end else begin
            state_nx_s = S_SEND;
`ifdef FLIT_LEN_CHECK_EN
            if (cnt_nx_s == length_r) err_set_s = 1'b1;
            else                      err_set_s = 1'b0;
`endif
          end
        end else begin
          // stalled by grant loss or starved: keep requesting
          state_nx_s = S_SEND;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; req tracks the next state so it is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      cnt_r         <= 12'd0;
      length_r      <= 12'd0;
      req_r         <= 1'b0;
      err_r         <= 1'b0;
      out_valid_r   <= 1'b0;
      out_flit_id_r <= 3'b000;
      out_data_r    <= '0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      length_r    <= length_nx_s;
      req_r       <= (state_nx_s != S_IDLE);
      err_r       <= err_r | err_set_s;
      out_valid_r <= fwd_s;
      if (fwd_s) begin
        out_flit_id_r <= head_id_s;
        out_data_r    <= head_data_s;
      end
    end
  end

endmodule

// File: tb/tb_flit_requester.sv
// Directed self-checking bench for flit_requester (DEPTH=4, DW=32).
module tb_flit_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_flit_id;
  logic [31:0] in_data;
  logic        in_ready;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        grant;
  logic        out_valid;
  logic [2:0]  out_flit_id;
  logic [31:0] out_data;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;
  logic exp_len_err;

  flit_requester #(.DEPTH(4), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_flit_id(in_flit_id), .in_data(in_data),
    .in_ready(in_ready), .req(req), .flit_id(flit_id), .length(length),
    .grant(grant),
    .out_valid(out_valid), .out_flit_id(out_flit_id), .out_data(out_data),
    .err(err)
  );

  always #5 clk = ~clk;

  // watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] id, input logic [31:0] d);
    in_valid   = v;
    in_flit_id = id;
    in_data    = d;
  endtask

  initial begin
`ifdef FLIT_LEN_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    rst = 1'b1; grant = 1'b0;
    drive(1'b0, 3'b000, 32'h0);
    tick(); tick();
    rst = 1'b0;
    check("rst_req",       {31'd0, req},       32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_flit_id",   {29'd0, flit_id},   32'd0);
    check("rst_length",    {20'd0, length},    32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_err",       {31'd0, err},       32'd0);

    // basic packet, grant from first req cycle
    drive(1'b1, 3'b001, 32'd3); tick();
    drive(1'b1, 3'b010, 32'hB1); tick();
    check("p1_req",     {31'd0, req},     32'd1);
    check("p1_flit_id", {29'd0, flit_id}, 32'd1);
    check("p1_length",  {20'd0, length},  32'd3);
    grant = 1'b1;
    drive(1'b1, 3'b100, 32'hC1); tick();
    drive(1'b0, 3'b000, 32'h0);
    check("p1_ov0", {31'd0, out_valid},   32'd1);
    check("p1_id0", {29'd0, out_flit_id}, 32'd1);
    check("p1_d0",  out_data,             32'd3);
    tick();
    check("p1_ov1", {31'd0, out_valid},   32'd1);
    check("p1_id1", {29'd0, out_flit_id}, 32'd2);
    check("p1_d1",  out_data,             32'hB1);
    tick();
    check("p1_ov2", {31'd0, out_valid},   32'd1);
    check("p1_id2", {29'd0, out_flit_id}, 32'd4);
    check("p1_d2",  out_data,             32'hC1);
    check("p1_req_fall", {31'd0, req},    32'd0);
    grant = 1'b0;
    tick();
    check("p1_ov_end", {31'd0, out_valid}, 32'd0);
    check("p1_err",    {31'd0, err},       32'd0);

    // grant dropped for 4 cycles after the header pop
    drive(1'b1, 3'b001, 32'd3); tick();
    drive(1'b1, 3'b010, 32'hB2); tick();
    drive(1'b1, 3'b100, 32'hC2); tick();
    drive(1'b0, 3'b000, 32'h0);
    check("p2_req_wait", {31'd0, req}, 32'd1);
    grant = 1'b1; tick();
    grant = 1'b0;
    check("p2_hdr_ov", {31'd0, out_valid},   32'd1);
    check("p2_hdr_id", {29'd0, out_flit_id}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p2_stall_ov",  {31'd0, out_valid}, 32'd0);
      check("p2_stall_req", {31'd0, req},       32'd1);
    end
    grant = 1'b1; tick();
    check("p2_body_ov", {31'd0, out_valid},   32'd1);
    check("p2_body_id", {29'd0, out_flit_id}, 32'd2);
    check("p2_body_d",  out_data,             32'hB2);
    tick();
    check("p2_tail_id", {29'd0, out_flit_id}, 32'd4);
    check("p2_tail_d",  out_data,             32'hC2);
    check("p2_req_fall", {31'd0, req},        32'd0);
    grant = 1'b0;
    tick();
    check("p2_ov_end", {31'd0, out_valid}, 32'd0);
    check("p2_err",    {31'd0, err},       32'd0);

    // FIFO full with 5 flits offered, grant held low
    drive(1'b1, 3'b001, 32'd5); tick();
    drive(1'b1, 3'b010, 32'hB3); tick();
    drive(1'b1, 3'b010, 32'hB4); tick();
    drive(1'b1, 3'b010, 32'hB5); tick();
    check("p3_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 3'b100, 32'hC3); tick();
    check("p3_full_hold1", {31'd0, in_ready}, 32'd0);
    tick();
    check("p3_full_hold2", {31'd0, in_ready}, 32'd0);
    check("p3_no_out",     {31'd0, out_valid}, 32'd0);
    grant = 1'b1; tick();
    check("p3_ready_after_pop", {31'd0, in_ready}, 32'd1);
    check("p3_hdr_id", {29'd0, out_flit_id}, 32'd1);
    tick();
    drive(1'b0, 3'b000, 32'h0);
    check("p3_b0_id", {29'd0, out_flit_id}, 32'd2);
    check("p3_b0_d",  out_data,             32'hB3);
    tick();
    check("p3_b1_d",  out_data,             32'hB4);
    tick();
    check("p3_b2_d",  out_data,             32'hB5);
    tick();
    check("p3_tail_id", {29'd0, out_flit_id}, 32'd4);
    check("p3_tail_d",  out_data,             32'hC3);
    check("p3_req_fall", {31'd0, req},        32'd0);
    grant = 1'b0;
    tick();
    check("p3_err", {31'd0, err}, 32'd0);

    // header length 4 but only 3 flits
    grant = 1'b1;
    drive(1'b1, 3'b001, 32'd4); tick();
    drive(1'b1, 3'b010, 32'hB6); tick();
    drive(1'b1, 3'b100, 32'hC6); tick();
    drive(1'b0, 3'b000, 32'h0);
    tick(); tick();
    check("p4_tail_ov", {31'd0, out_valid},   32'd1);
    check("p4_tail_id", {29'd0, out_flit_id}, 32'd4);
    check("p4_tail_d",  out_data,             32'hC6);
    grant = 1'b0;
    tick();
    check("p4_err", {31'd0, err}, {31'd0, exp_len_err});

    // stray body in IDLE is discarded
    rst = 1'b1; tick(); rst = 1'b0;
    check("p5_err_clr", {31'd0, err}, 32'd0);
    drive(1'b1, 3'b010, 32'hDD); tick();
    drive(1'b0, 3'b000, 32'h0);
    check("p5_head", {29'd0, flit_id}, 32'd2);
    tick();
    check("p5_err_set", {31'd0, err},       32'd1);
    check("p5_empty",   {29'd0, flit_id},   32'd0);
    check("p5_ov0",     {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p5_ov",     {31'd0, out_valid}, 32'd0);
      check("p5_sticky", {31'd0, err},       32'd1);
      check("p5_req",    {31'd0, req},       32'd0);
    end

    // reset in SEND with 2 flits buffered
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 3'b001, 32'd4); tick();
    drive(1'b1, 3'b010, 32'hB7); tick();
    drive(1'b1, 3'b010, 32'hB8); tick();
    drive(1'b0, 3'b000, 32'h0);
    grant = 1'b1; tick();
    grant = 1'b0;
    check("p6_send_req", {31'd0, req},     32'd1);
    check("p6_send_hd",  {29'd0, flit_id}, 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("p6_req",       {31'd0, req},       32'd0);
    check("p6_in_ready",  {31'd0, in_ready},  32'd1);
    check("p6_flit_id",   {29'd0, flit_id},   32'd0);
    check("p6_out_valid", {31'd0, out_valid}, 32'd0);
    check("p6_length",    {20'd0, length},    32'd0);
    check("p6_err",       {31'd0, err},       32'd0);
    grant = 1'b1; tick();
    check("p6_no_tail", {31'd0, out_valid}, 32'd0);
    check("p6_idle",    {31'd0, req},       32'd0);
    grant = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
